// File: rtl/score_overlay_pkg.sv
// Shared types, register map, digit font and BCD increment helper for score_overlay.
// Latency: n/a (package only).
// Backpressure: n/a.
package score_overlay_pkg;

  typedef logic [3:0] bcd_digit_t;

  // Result of a BCD increment: updated value plus carry out of the top digit.
  typedef struct packed {
    logic        carry;
    logic [31:0] value;
  } bcd_inc_t;

  localparam logic [2:0] ADDR_SCORE = 3'd0;
  localparam logic [2:0] ADDR_POS_X = 3'd1;
  localparam logic [2:0] ADDR_POS_Y = 3'd2;
  localparam logic [2:0] ADDR_CTRL  = 3'd3;
  localparam logic [2:0] ADDR_HICLR = 3'd4;

  // 8x8 glyphs for digits 0-9, one byte per row, MSB is the leftmost pixel.
  localparam logic [7:0] FONT [0:9][0:7] = '{
    '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
    '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
    '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
    '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},
    '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
    '{8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00},
    '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00}
  };

  // Add 1 to the low ndig BCD digits of v; digits above ndig pass through.
  // carry is set when every active digit was 9 (the value wraps to zero).
  function automatic bcd_inc_t bcd_inc(input logic [31:0] v, input int ndig);
    bcd_inc_t r;
    logic     c;
    c       = 1'b1;
    r.value = v;
    for (int i = 0; i < 8; i++) begin
      if (i < ndig && c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r.value[4*i +: 4] = 4'd0;
        end else begin
          r.value[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    r.carry = c;
    return r;
  endfunction

endpackage

// File: rtl/score_font_rom.sv
// Combinational glyph row lookup for one BCD digit.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: digit[3:0] BCD digit, row[2:0] glyph row, glyph[7:0] row bits (MSB leftmost).
module score_font_rom
  import score_overlay_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [2:0] row,
  output logic [7:0] glyph
);

  // Non-decimal codes never reach here in normal operation; render them blank.
  always_comb begin
    glyph = 8'h00;
    if (digit <= 4'd9) glyph = FONT[digit][row];
  end

endmodule

// File: rtl/score_overlay.sv
// BCD score/high-score engine with a frame-synchronous scaled glyph overlay.
// Latency: registers 1 cycle after strobe; pix_on 2 cycles after hcount/vcount.
// Backpressure: none; writes, ticks and pixels accepted every cycle.
// Ports: clk, reset_n (async, active low); chipselect/write/address/writedata
//   register port; tick/clear game strobes; hcount/vcount current pixel;
//   pix_on overlay foreground; score_bcd/hiscore_bcd live values; overflow sticky.
// Build option: SCORE_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module score_overlay
  import score_overlay_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCALE_LOG2 = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  chipselect,
  input  logic                  write,
  input  logic [2:0]            address,
  input  logic [31:0]           writedata,
  input  logic                  tick,
  input  logic                  clear,
  input  logic [10:0]           hcount,
  input  logic [9:0]            vcount,
  output logic                  pix_on,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   hiscore_bcd,
  output logic                  overflow
);

  localparam int         W     = 4 * DIGITS;
  localparam logic [11:0] REG_W = 12'((DIGITS * 8) << SCALE_LOG2);
  localparam logic [11:0] REG_H = 12'(8 << SCALE_LOG2);

  logic [W-1:0] score, hiscore, shown;
  logic [10:0]  pos_x;
  logic [9:0]   pos_y;
  logic         count_en, show_hi;

  logic         wr_en;
  logic [W-1:0] load_val;
  bcd_inc_t     inc;

  assign wr_en       = chipselect && write;
  assign inc         = bcd_inc(32'(score), DIGITS);
  assign score_bcd   = score;
  assign hiscore_bcd = hiscore;

  // Out-of-range load nibbles saturate to 9 so the score stays valid BCD.
  always_comb begin
    load_val = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_val[4*i +: 4] = (writedata[4*i +: 4] > 4'd9) ? 4'd9 : writedata[4*i +: 4];
    end
  end

  // Score engine: clear beats a score load, which beats a tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score    <= '0;
      hiscore  <= '0;
      shown    <= '0;
      pos_x    <= '0;
      pos_y    <= '0;
      count_en <= 1'b0;
      show_hi  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (clear) begin
        score    <= '0;
        overflow <= 1'b0;
      end else if (wr_en && address == ADDR_SCORE) begin
        score    <= load_val;
        overflow <= 1'b0;
      end else if (tick && count_en) begin
        // At all-9s the increment would wrap; hold instead and flag it.
        if (inc.carry) overflow <= 1'b1;
        else           score    <= inc.value[W-1:0];
      end

      // Packed BCD orders the same as unsigned binary, so a plain compare works.
      if (wr_en && address == ADDR_HICLR) hiscore <= '0;
      else if (clear && score > hiscore)  hiscore <= score;

      if (wr_en && address == ADDR_POS_X) pos_x <= writedata[10:0];
      if (wr_en && address == ADDR_POS_Y) pos_y <= writedata[9:0];
      if (wr_en && address == ADDR_CTRL) begin
        count_en <= writedata[0];
        show_hi  <= writedata[1];
      end

      // Latch the displayed value once per frame so a mid-frame change cannot tear.
      if (hcount == 11'd0 && vcount == 10'd0) shown <= show_hi ? hiscore : score;
    end
  end

  // ---------------- Render stage 1: region hit and digit select ----------------
  logic [11:0] hx, vy, px, py, dx, dy;
  logic        in_x, in_y, blank;
  logic [5:0]  lx;
  logic [2:0]  ly, dig_idx;
  logic [3:0]  nib;

  // 12-bit math so a region hanging off the right/bottom edge clips, not wraps.
  assign hx      = {1'b0, hcount};
  assign vy      = {2'b0, vcount};
  assign px      = {1'b0, pos_x};
  assign py      = {2'b0, pos_y};
  assign in_x    = (hx >= px) && (hx < px + REG_W);
  assign in_y    = (vy >= py) && (vy < py + REG_H);
  assign dx      = hx - px;
  assign dy      = vy - py;
  assign lx      = 6'(dx >> SCALE_LOG2);
  assign ly      = 3'(dy >> SCALE_LOG2);
  assign dig_idx = lx[5:3];

  // Digit 0 on screen is the most significant nibble.
  always_comb begin
    nib = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_idx == 3'(i)) nib = shown[4*(DIGITS-1-i) +: 4];
    end
  end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  // A digit is blank when it and everything to its left are zero; the
  // rightmost digit is exempt so a zero value still shows "0".
  logic lead;
  always_comb begin
    lead  = 1'b1;
    blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      lead = lead && (shown[4*(DIGITS-1-i) +: 4] == 4'd0);
      if (dig_idx == 3'(i)) blank = lead && (i != DIGITS - 1);
    end
  end
`else
  assign blank = 1'b0;
`endif

  logic       s1_hit;
  logic [3:0] s1_nib;
  logic [2:0] s1_row, s1_col;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_hit <= 1'b0;
      s1_nib <= 4'd0;
      s1_row <= 3'd0;
      s1_col <= 3'd0;
    end else begin
      s1_hit <= in_x && in_y && !blank;
      s1_nib <= nib;
      s1_row <= ly;
      s1_col <= lx[2:0];
    end
  end

  // ---------------- Render stage 2: font lookup ----------------
  logic [7:0] glyph;

  score_font_rom u_font (
    .digit (s1_nib),
    .row   (s1_row),
    .glyph (glyph)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pix_on <= 1'b0;
    else          pix_on <= s1_hit && glyph[3'd7 - s1_col];
  end

  logic unused_bits;
  assign unused_bits = ^{writedata, inc.value};

endmodule

// File: tb/tb_score_overlay.sv
module tb_score_overlay;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect, write, tick, clear;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        pix_on, overflow;
  logic [15:0] score_bcd, hiscore_bcd;

  int n_cmp = 0;
  int n_err = 0;

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  localparam logic LZ = 1'b1;
`else
  localparam logic LZ = 1'b0;
`endif

  score_overlay #(.DIGITS(4), .SCALE_LOG2(1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .chipselect  (chipselect),
    .write       (write),
    .address     (address),
    .writedata   (writedata),
    .tick        (tick),
    .clear       (clear),
    .hcount      (hcount),
    .vcount      (vcount),
    .pix_on      (pix_on),
    .score_bcd   (score_bcd),
    .hiscore_bcd (hiscore_bcd),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    step();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic snapshot();
    hcount = 11'd0; vcount = 10'd0;
    step();
    hcount = 11'd1000; vcount = 10'd400;
  endtask

  // Present one pixel, then read pix_on two edges later.
  task automatic pix(input string tag, input int h, input int v, input logic exp);
    hcount = 11'(h); vcount = 10'(v);
    step();
    hcount = 11'd1000; vcount = 10'd400;
    step();
    chk(tag, {31'd0, pix_on}, {31'd0, exp});
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write = 1'b0; address = 3'd0;
    writedata = 32'd0; tick = 1'b0; clear = 1'b0;
    hcount = 11'd1000; vcount = 10'd400;
    #12;
    chk("rst_score",   score_bcd,   0);
    chk("rst_hiscore", hiscore_bcd, 0);
    chk("rst_ovf",     overflow,    0);
    chk("rst_pix",     pix_on,      0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    step();

    // Counting enabled, then disabled.
    wr(3'd3, 32'h1);
    tick = 1'b1; step(); step(); step(); tick = 1'b0;
    chk("tick3", score_bcd, 32'h0003);
    wr(3'd3, 32'h0);
    tick = 1'b1; step(); step(); step(); tick = 1'b0;
    chk("tick_dis", score_bcd, 32'h0003);
    wr(3'd3, 32'h1);

    // Decimal carry and saturation.
    wr(3'd0, 32'h0099);
    tick = 1'b1; step(); tick = 1'b0;
    chk("carry", score_bcd, 32'h0100);
    wr(3'd0, 32'h9999);
    tick = 1'b1; step(); step(); tick = 1'b0;
    chk("sat_score", score_bcd, 32'h9999);
    chk("sat_ovf",   overflow,  1);
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_ovf",   overflow,    0);
    chk("clr_hi",    hiscore_bcd, 32'h9999);
    chk("clr_score", score_bcd,   0);

    // Overflow also cleared by a score load.
    wr(3'd0, 32'h9999);
    tick = 1'b1; step(); tick = 1'b0;
    chk("ovf_again", overflow, 1);
    wr(3'd0, 32'h0001);
    chk("ld_ovf", overflow, 0);

    // Same-cycle priorities and load saturation.
    clear = 1'b1; chipselect = 1'b1; write = 1'b1; address = 3'd0; writedata = 32'h0042;
    step();
    clear = 1'b0; chipselect = 1'b0; write = 1'b0;
    chk("clr_vs_ld", score_bcd, 0);
    chk("clr_hi_keep", hiscore_bcd, 32'h9999);
    tick = 1'b1; chipselect = 1'b1; write = 1'b1; address = 3'd0; writedata = 32'h0042;
    step();
    tick = 1'b0; chipselect = 1'b0; write = 1'b0;
    chk("ld_vs_tick", score_bcd, 32'h0042);
    wr(3'd0, 32'h00A5);
    chk("ld_sat", score_bcd, 32'h0095);

    // Hiscore clear together with round clear, then max() behaviour.
    clear = 1'b1; chipselect = 1'b1; write = 1'b1; address = 3'd4; writedata = 32'hFFFF;
    step();
    clear = 1'b0; chipselect = 1'b0; write = 1'b0;
    chk("hiclr_clr", hiscore_bcd, 0);
    chk("hiclr_score", score_bcd, 0);
    wr(3'd0, 32'h0300);
    clear = 1'b1; step(); clear = 1'b0;
    chk("hi_up", hiscore_bcd, 32'h0300);
    wr(3'd0, 32'h0120);
    clear = 1'b1; step(); clear = 1'b0;
    chk("hi_keep", hiscore_bcd, 32'h0300);

    // Rendering: shown = 0x1000 at (100,50), scale x2, region 100..163 x 50..65.
    wr(3'd0, 32'h1000);
    wr(3'd1, 32'd100);
    wr(3'd2, 32'd50);
    snapshot();
    pix("pix_1_r0",    106, 50, 1'b1);
    pix("pix_left",     99, 50, 1'b0);
    pix("pix_1_r0_b5", 104, 50, 1'b0);
    pix("pix_1_r0b",   107, 51, 1'b1);
    pix("pix_1_r6",    102, 62, 1'b1);
    pix("pix_d3_r1",   160, 52, 1'b1);
    pix("pix_right",   164, 52, 1'b0);
    pix("pix_below",   106, 66, 1'b0);

    // Mid-frame score change must not show until the next snapshot.
    wr(3'd0, 32'h0007);
    pix("mid_frame", 104, 200 - 150, 1'b0);
    snapshot();
    pix("new_d0_lz", 104, 50, !LZ);
    pix("new_d3_7",  150, 50, 1'b1);
    wr(3'd0, 32'h0000);
    snapshot();
    pix("zero_d3",   152, 50, 1'b1);
    pix("zero_d2",   136, 50, !LZ);

    // Display the high score (0x0300).
    wr(3'd3, 32'h2);
    snapshot();
    pix("hi_d1_3",   120, 50, 1'b1);
    pix("hi_d2_0",   136, 50, 1'b1);

    // Asynchronous reset clears pix_on immediately.
    hcount = 11'd120; vcount = 10'd50;
    step();
    hcount = 11'd1000; vcount = 10'd400;
    step();
    chk("pre_arst_pix", pix_on, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_pix",   pix_on,      0);
    chk("arst_hi",    hiscore_bcd, 0);
    step();
    reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/score_overlay.md
# score_overlay

Parametrised multi-digit score engine and pixel-overlay renderer for the VGA sprite pipeline. It holds a packed-BCD score and high score, advances the score on game ticks with BCD carry, and takes register writes from the Avalon-style slave port. It renders the selected value as scaled 8x8 glyphs at a programmable screen position, producing a 1-bit `pix_on` that the sprite compositor uses to force foreground colour. The displayed value is frame-synchronous, so the overlay never tears.

## Interface
- `DIGITS`, 4: number of BCD digits (1..8).
- `SCALE_LOG2`, 1: glyph magnification 2^SCALE_LOG2 (0..3).
- `clk` in 1: pixel/system clock, the same clock as `vga_counters`.
- `reset_n` in 1: asynchronous, active-low reset.
- `chipselect` in 1: slave select.
- `write` in 1: write strobe, qualified by `chipselect`.
- `address` in 3: register index.
- `writedata` in 32: write data.
- `tick` in 1: single-cycle score-increment pulse.
- `clear` in 1: single-cycle round-end pulse.
- `hcount` in 11: current horizontal pixel.
- `vcount` in 10: current vertical pixel.
- `pix_on` out 1: glyph foreground at the pixel presented 2 cycles earlier.
- `score_bcd` out 4*DIGITS: live score.
- `hiscore_bcd` out 4*DIGITS: high score.
- `overflow` out 1: sticky saturation flag.

## Operation
- Registers (write-only, one cycle):
  - 0 = score load from `writedata[4*DIGITS-1:0]`. Any nibble >9 is stored as 9.
  - 1 = `pos_x` from `[10:0]`.
  - 2 = `pos_y` from `[9:0]`.
  - 3 = ctrl: bit0 `count_en`, bit1 `show_hi`.
  - 4 = hiscore clear (data ignored).
  - 5..7 ignored.
- Increment: `tick && count_en` adds 1 to `score` with a decimal carry chain, digit 0 least significant.
  - At all-9s the score holds and `overflow` sets.
  - `overflow` clears on `clear` or on a register-0 write.
- Clear:
  - `hiscore <= max(hiscore, score)`. Packed-BCD compares numerically as unsigned binary.
  - Then `score <= 0`.
- Priority in the same cycle: `clear` > register-0 write > `tick`. A hiscore-clear write on the same cycle as `clear` leaves `hiscore` = 0.
- Frame snapshot:
  - At `hcount==0 && vcount==0`, `shown <= show_hi ? hiscore : score` (register values before that cycle's updates).
  - Rendering uses `shown` only.
- Geometry:
  - The region is `pos_x <= hcount < pos_x + DIGITS*8<<SCALE_LOG2` and `pos_y <= vcount < pos_y + 8<<SCALE_LOG2`.
  - Compute in 12-bit; no wrap at the screen edge. A region past 1279/479 is clipped by the compare.
  - `lx = (hcount-pos_x)>>SCALE_LOG2` and `ly = (vcount-pos_y)>>SCALE_LOG2`.
  - Digit index `lx[..:3]` counts from the left (most significant first).
  - Glyph row is `ly[2:0]`, bit `7-lx[2:0]` of the font byte.
- Reset values: score, hiscore, shown, pos_x, pos_y and ctrl are all 0. `overflow`=0 and `pix_on`=0. Pipeline valid bits are 0.

## Timing
- Register writes and `tick`/`clear` take effect on the next `clk` edge. `score_bcd`/`hiscore_bcd` reflect them 1 cycle after the strobe.
- Render pipeline latency is exactly 2 cycles.
  - S1 registers the hit flag, digit nibble, row and column.
  - S2 registers the font bit ANDed with hit.
- `pix_on` is 0 whenever the S1 hit flag was 0.
- Back-to-back `tick` every cycle is supported with no lost increments.
- Asserting `reset_n` mid-frame forces `pix_on`=0 the same cycle (asynchronous). The first post-reset frame displays 0 only after the next snapshot point; before that `shown`=0 anyway.

## Configuration
- `SCORE_LEADING_ZERO_BLANK_EN`
  - Defined: leading-zero digits (all digits more significant than the highest nonzero digit) render blank. The least significant digit always renders, so a value of 0 shows "0".
  - Undefined: all DIGITS glyphs render, including zeros.
- Blanking is decided in S1 from `shown`. Latency is unchanged.

## Structure
- `score_overlay_pkg` holds:
  - the 10x8 font constant (digits 0-9, 8-bit rows, MSB leftmost);
  - register-address localparams;
  - the BCD-digit typedef;
  - the function `bcd_inc` (returns value and carry-out).
- Sub-module `score_font_rom` is a combinational glyph lookup, (digit[3:0], row[2:0]) -> byte[7:0], indexed from the package constant. Instantiated in S2.

## Test plan
- Reset, then 3 `tick` with `count_en`=1 -> `score_bcd`=0x0003. Repeat with `count_en`=0 -> unchanged.
- Load 0x0099, one `tick` -> 0x0100. Load 0x9999, two `tick` -> 0x9999 and `overflow`=1. `clear` -> `overflow`=0, `hiscore_bcd`=0x9999.
- `clear` and a register-0 write of 0x0042 in the same cycle -> score 0. Register-0 write of 0x0042 and `tick` in the same cycle -> 0x0042. Write 0x00A5 -> 0x0095.
- `pos_x`=100, `pos_y`=50, `SCALE_LOG2`=1, shown=0x1000: pixel (100+2*3, 50+2*0) -> `pix_on`=1 two cycles later (digit '1', row 0 = 0x18, bit 4). Pixel (99, 50) -> 0.
- Change score mid-frame (vcount=200) -> `pix_on` pattern for rest of the frame is unchanged; the new value appears from the next frame.
- With `SCORE_LEADING_ZERO_BLANK_EN`, shown=0x0007 -> digits 0-2 produce no `pix_on`, digit 3 renders '7'. With shown=0, only the rightmost '0' renders.
